// File: rtl/encoder_pool_stage.sv
// Streaming 2x2 signed max-pool for the encoder path: forwards every accepted
// sample on the skip port and emits one pooled maximum per 2x2 window.
//
// state | meaning
// IDLE  | waiting for start; counters cleared on start
// RUN   | accepting samples, channel-planar raster order
// DRAIN | last sample taken, waiting for the final pooled result to leave
// DONE  | one-cycle done pulse, then back to IDLE
module encoder_pool_stage #(
  parameter int INPUT_WIDTH  = 16,
  parameter int INPUT_HEIGHT = 16,
  parameter int CHANNELS     = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_skip_valid,
  output logic [DATA_WIDTH-1:0] o_skip_data,
  output logic                  o_pool_valid,
  input  logic                  i_pool_ready,
  output logic [DATA_WIDTH-1:0] o_pool_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int COL_W = $clog2(INPUT_WIDTH);
  localparam int ROW_W = $clog2(INPUT_HEIGHT);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int LB_N  = INPUT_WIDTH / 2;
  localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [CH_W-1:0]       r_ch;
  logic [DATA_WIDTH-1:0] r_h;
  logic [DATA_WIDTH-1:0] r_lb [LB_N];
  logic [DATA_WIDTH-1:0] r_pool_data;
  logic                  r_pool_valid;
  logic [DATA_WIDTH-1:0] r_skip_data;
  logic                  r_skip_valid;

  logic                  w_accept;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_last_ch;
  logic                  w_last_sample;
  logic                  w_pool_load;
  logic                  w_lb_write;
  logic [LB_AW-1:0]      w_lb_idx;
  logic [DATA_WIDTH-1:0] w_max_hs;
  logic [DATA_WIDTH-1:0] w_max3;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign o_in_ready    = (r_state == S_RUN) && !(r_pool_valid && !i_pool_ready);
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_last_col    = (r_col == COL_W'(INPUT_WIDTH - 1));
  assign w_last_row    = (r_row == ROW_W'(INPUT_HEIGHT - 1));
  assign w_last_ch     = (r_ch == CH_W'(CHANNELS - 1));
  assign w_last_sample = w_last_col && w_last_row && w_last_ch;
  assign w_lb_idx      = LB_AW'(r_col >> 1);
  assign w_max_hs      = smax(r_h, i_in_data);
  assign w_max3        = smax(r_lb[w_lb_idx], w_max_hs);
  assign w_lb_write    = w_accept && !r_row[0] && r_col[0];
  assign w_pool_load   = w_accept && r_row[0] && r_col[0];

  assign o_skip_valid  = r_skip_valid;
  assign o_skip_data   = r_skip_data;
  assign o_pool_valid  = r_pool_valid;
  assign o_pool_data   = r_pool_data;
  assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last_sample) w_next = S_DRAIN;
      S_DRAIN: if (!r_pool_valid || i_pool_ready) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_ch         <= '0;
      r_h          <= '0;
      r_pool_data  <= '0;
      r_pool_valid <= 1'b0;
      r_skip_data  <= '0;
      r_skip_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_skip_valid <= w_accept;
      if (w_accept) r_skip_data <= i_in_data;

      if (r_state == S_IDLE && i_start) begin
        r_col <= '0;
        r_row <= '0;
        r_ch  <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row <= '0;
            r_ch  <= w_last_ch ? '0 : r_ch + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_accept && !r_col[0]) r_h <= i_in_data;

      // A new result may load in the same cycle the old one is taken.
      if (w_pool_load) begin
        r_pool_data  <= w_max3;
        r_pool_valid <= 1'b1;
      end else if (r_pool_valid && i_pool_ready) begin
        r_pool_valid <= 1'b0;
      end
    end
  end

  // Every entry is rewritten on the even row before the odd row reads it.
  always_ff @(posedge i_clk) begin
    if (w_lb_write) r_lb[w_lb_idx] <= w_max_hs;
  end

endmodule
